// File: rtl/s_wb_pkg.sv
// Shared types and constants for the scalar result writeback controller.
// Unit ids, fixed unit latencies, and the in-flight slot record.
package s_wb_pkg;

  localparam int S_REGS = 8;
  localparam int UNIT_W = 2;
  localparam int DEST_W = 3;
  localparam int LAT_W  = 3;
  localparam int DATA_W = 64;

  localparam logic [UNIT_W-1:0] UNIT_CONST = 2'd0;
  localparam logic [UNIT_W-1:0] UNIT_LOGIC = 2'd1;
  localparam logic [UNIT_W-1:0] UNIT_ADD   = 2'd2;
  localparam logic [UNIT_W-1:0] UNIT_SHIFT = 2'd3;

  typedef struct packed {
    logic              valid;
    logic [UNIT_W-1:0] unit;
    logic [DEST_W-1:0] dest;
  } slot_t;

  // Edges from the accepting edge until the result sits at the unit output.
  function automatic logic [LAT_W-1:0] unit_lat(input logic [UNIT_W-1:0] unit);
    logic [LAT_W-1:0] lat;
    case (unit)
      UNIT_CONST, UNIT_LOGIC: lat = 3'd2;
      UNIT_ADD, UNIT_SHIFT:   lat = 3'd3;
      default:                lat = 3'd2;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/s_wb_slot_chain.sv
// Fixed-latency slot chain: shifts toward slot 0 each edge, loads new ops at lat-1.
// Reports whether a given slot is occupied so issue can avoid write-port collisions.
module s_wb_slot_chain
  import s_wb_pkg::*;
#(
  parameter int MAX_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [LAT_W-1:0] load_pos,
  input  slot_t            load_slot,
  input  logic [LAT_W-1:0] query_pos,
  output logic             query_busy,
  output slot_t            head
);

  slot_t slot    [MAX_LAT];
  slot_t shifted [MAX_LAT];

  always_comb begin
    for (int k = 0; k < MAX_LAT - 1; k++) begin
      shifted[k] = slot[k+1];
    end
    shifted[MAX_LAT-1] = '0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (load_en && load_pos == LAT_W'(k)) begin
        shifted[k] = load_slot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        slot[k] <= '0;
      end
    end else begin
      for (int k = 0; k < MAX_LAT; k++) begin
        slot[k] <= shifted[k];
      end
    end
  end

  // Positions at or beyond MAX_LAT never match, so they read as empty.
  always_comb begin
    query_busy = 1'b0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (query_pos == LAT_W'(k)) begin
        query_busy = slot[k].valid;
      end
    end
  end

  assign head = slot[0];

endmodule

// File: rtl/s_wb_ctrl.sv
// Scalar writeback controller: grants issue, tracks S-register reservations, drives the write port.
// Result written lat+1 edges after issue; no register-file backpressure, hazards stall issue.
module s_wb_ctrl
  import s_wb_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int MAX_LAT   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_issue,
  input  logic [UNIT_W-1:0]           i_unit,
  input  logic [DEST_W-1:0]           i_dest,
  output logic                        o_issue_ok,
  input  logic [DATA_W*NUM_UNITS-1:0] i_unit_res,
  output logic [S_REGS-1:0]           o_s_busy,
  output logic                        o_we,
  output logic [DEST_W-1:0]           o_waddr,
  output logic [DATA_W-1:0]           o_wdata
);

  logic [LAT_W-1:0]  req_lat;
  logic              unit_ok;
  logic              port_taken;
  logic              accept;
  slot_t             req_slot;
  slot_t             head;
  logic [S_REGS-1:0] s_busy;
  logic [DATA_W-1:0] wb_data;

  assign req_lat  = unit_lat(i_unit);
  assign unit_ok  = 32'(i_unit) < NUM_UNITS;
  assign req_slot = '{valid: 1'b1, unit: i_unit, dest: i_dest};

  // An op already in slot[lat] would shift into our load position and share our write edge.
  assign o_issue_ok = unit_ok && !s_busy[i_dest] && !port_taken;
  assign accept     = i_issue && o_issue_ok;

  s_wb_slot_chain #(
    .MAX_LAT (MAX_LAT)
  ) u_chain (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (accept),
    .load_pos   (req_lat - LAT_W'(1)),
    .load_slot  (req_slot),
    .query_pos  (req_lat),
    .query_busy (port_taken),
    .head       (head)
  );

  always_comb begin
    wb_data = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (head.unit == UNIT_W'(u)) begin
        wb_data = i_unit_res[DATA_W*u +: DATA_W];
      end
    end
  end

  // Reservation clears on the commit edge, i.e. while o_we for that register is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_busy <= '0;
    end else begin
      if (o_we) begin
        s_busy[o_waddr] <= 1'b0;
      end
      if (accept) begin
        s_busy[i_dest] <= 1'b1;
      end
    end
  end

  assign o_s_busy = s_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_we    <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      o_we <= head.valid;
      if (head.valid) begin
        o_waddr <= head.dest;
        o_wdata <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_s_wb_ctrl.sv
// Bench for s_wb_ctrl: directed hazard scenarios plus random traffic against a
// write-schedule model indexed by commit edge.
module tb_s_wb_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         issue;
  logic [1:0]   unit;
  logic [2:0]   dest;
  logic         o_issue_ok;
  logic [255:0] res;
  logic [7:0]   o_s_busy;
  logic         o_we;
  logic [2:0]   o_waddr;
  logic [63:0]  o_wdata;

  s_wb_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_issue    (issue),
    .i_unit     (unit),
    .i_dest     (dest),
    .o_issue_ok (o_issue_ok),
    .i_unit_res (res),
    .o_s_busy   (o_s_busy),
    .o_we       (o_we),
    .o_waddr    (o_waddr),
    .o_wdata    (o_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: n edges since reset; writes are booked by the edge that raises o_we.
  int          n;
  int          clear_edge [8];
  bit          sched_vld  [16];
  logic [2:0]  sched_dest [16];
  logic [1:0]  sched_unit [16];
  logic        m_we;
  logic [2:0]  m_waddr;
  logic [63:0] m_wdata;
  int          lat_tab [4] = '{2, 2, 3, 3};

  bit          fixed_en;
  logic [63:0] fixed_val;
  bit          last_ok;
  int          we_seen;
  int          rejects;
  int          accepts;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 8; i++) clear_edge[i] = 0;
    for (int i = 0; i < 16; i++) sched_vld[i] = 1'b0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic cycle(input bit iss, input logic [1:0] u, input logic [2:0] d);
    logic [7:0] exp_busy;
    bit         pred;
    int         e;
    int         lat;
    int         slot;
    @(negedge clk);
    for (int i = 0; i < 8; i++) exp_busy[i] = clear_edge[i] > n;
    check("we", 64'(o_we), 64'(m_we));
    check("waddr", 64'(o_waddr), 64'(m_waddr));
    check("wdata", o_wdata, m_wdata);
    check("busy", 64'(o_s_busy), 64'(exp_busy));
    if (o_we) we_seen++;
    issue = iss;
    unit  = u;
    dest  = d;
    for (int k = 0; k < 4; k++) res[64*k +: 64] = {$urandom, $urandom};
    if (fixed_en) res[63:0] = fixed_val;
    e    = n + 1;
    lat  = lat_tab[u];
    pred = (clear_edge[d] <= n) && !sched_vld[(e + lat) % 16];
    #1;
    check("issue_ok", 64'(o_issue_ok), 64'(pred));
    last_ok = o_issue_ok;
    @(posedge clk);
    slot = e % 16;
    if (sched_vld[slot]) begin
      m_we    = 1'b1;
      m_waddr = sched_dest[slot];
      m_wdata = res[64*int'(sched_unit[slot]) +: 64];
      sched_vld[slot] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (iss && pred) begin
      slot = (e + lat) % 16;
      sched_vld[slot]  = 1'b1;
      sched_dest[slot] = d;
      sched_unit[slot] = u;
      clear_edge[d]    = e + lat + 1;
    end
    n = e;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    issue     = 1'b0;
    unit      = 2'd0;
    dest      = 3'd0;
    res       = '0;
    fixed_en  = 1'b0;
    fixed_val = 64'o0400014000000000000000;
    we_seen   = 0;
    model_reset();

    // Reset state and first grant
    repeat (3) @(posedge clk);
    #2;
    check("rst_we", 64'(o_we), 64'd0);
    check("rst_busy", 64'(o_s_busy), 64'd0);
    check("rst_waddr", 64'(o_waddr), 64'd0);
    check("rst_wdata", o_wdata, 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_issue_ok_unit0", 64'(o_issue_ok), 64'd1);

    // UNIT_CONST to S3 with a fixed result on bus 0 at E2
    cycle(1'b1, 2'd0, 3'd3);
    #2 check("const_busy_set", 64'(o_s_busy[3]), 64'd1);
    cycle(1'b0, 2'd0, 3'd0);
    fixed_en = 1'b1;
    cycle(1'b0, 2'd0, 3'd0);
    fixed_en = 1'b0;
    #2;
    check("const_we", 64'(o_we), 64'd1);
    check("const_waddr", 64'(o_waddr), 64'd3);
    check("const_wdata", o_wdata, 64'o0400014000000000000000);
    cycle(1'b0, 2'd0, 3'd0);
    #2;
    check("const_busy_clear", 64'(o_s_busy[3]), 64'd0);
    check("const_we_drop", 64'(o_we), 64'd0);

    // UNIT_ADD to S1 then UNIT_CONST to S2: write-port collision, then accepted
    cycle(1'b1, 2'd2, 3'd1);
    cycle(1'b1, 2'd0, 3'd2);
    check("collide_reject", 64'(last_ok), 64'd0);
    cycle(1'b1, 2'd0, 3'd2);
    check("collide_retry_ok", 64'(last_ok), 64'd1);
    cycle(1'b0, 2'd0, 3'd0);
    #2;
    check("collide_first_we", 64'(o_we), 64'd1);
    check("collide_first_addr", 64'(o_waddr), 64'd1);
    cycle(1'b0, 2'd0, 3'd0);
    #2;
    check("collide_second_we", 64'(o_we), 64'd1);
    check("collide_second_addr", 64'(o_waddr), 64'd2);

    // Destination hazard on S4: rejected until the commit edge has passed
    cycle(1'b1, 2'd1, 3'd4);
    check("s4_first_ok", 64'(last_ok), 64'd1);
    rejects = 0;
    for (int t = 0; t < 10; t++) begin
      cycle(1'b1, 2'd0, 3'd4);
      if (last_ok) break;
      rejects++;
    end
    check("s4_retry_accept", 64'(last_ok), 64'd1);
    check("s4_retry_rejects", 64'(rejects), 64'd3);
    repeat (4) cycle(1'b0, 2'd0, 3'd0);

    // UNIT_SHIFT every cycle to rotating destinations
    we_seen = 0;
    accepts = 0;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 2'd3, 3'(k % 8));
      if (last_ok) accepts++;
    end
    repeat (5) cycle(1'b0, 2'd0, 3'd0);
    check("shift_accepts", 64'(accepts), 64'd16);
    check("shift_writes", 64'(we_seen), 64'd16);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      cycle(($urandom % 4) != 0, 2'($urandom), 3'($urandom));
    end

    // Reset mid-flight with two ops pending
    repeat (4) cycle(1'b0, 2'd0, 3'd0);
    cycle(1'b1, 2'd2, 3'd5);
    cycle(1'b1, 2'd3, 3'd6);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_we", 64'(o_we), 64'd0);
    check("midrst_busy", 64'(o_s_busy), 64'd0);
    check("midrst_waddr", 64'(o_waddr), 64'd0);
    check("midrst_wdata", o_wdata, 64'd0);
    issue = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    we_seen = 0;
    repeat (6) cycle(1'b0, 2'd0, 3'd0);
    check("midrst_no_write", 64'(we_seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
